// File: rtl/frame_mem_arbiter_pkg.sv
// Shared definitions for the frame memory subsystem.
// Holds the default geometry of the frame memory, which the VGA controller,
// the Game of Life engine and the memory controller also use, and the tag
// that marks which requester a read belongs to.
package frame_mem_arbiter_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int MEM_LAT_DEF  = 3;
    localparam int MAX_WAIT_DEF = 8;

    // Requester that issued a read.
    typedef enum logic {
        TAG_DISP = 1'b0,
        TAG_GAME = 1'b1
    } tag_e;

    // One slot of the read-return pipeline.
    typedef struct packed {
        logic valid;
        tag_e tag;
    } rd_tag_t;

endpackage

// File: rtl/frame_mem_arbiter_if.sv
// Bundle of the display client, game client and memory controller signals
// around the frame memory arbiter.
//   slave  : the arbiter's view (client requests and memory responses in,
//            acks, return data and memory commands out)
//   master : the surrounding system's view (clients plus memory controller)
interface frame_mem_arbiter_if
    import frame_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // display client
    logic              dReq;
    logic [ADDR_W-1:0] dAddr;
    logic              dAck;
    logic              dValid;
    logic [DATA_W-1:0] dData;
    // game client
    logic              gReq;
    logic              gWe;
    logic [ADDR_W-1:0] gAddr;
    logic [DATA_W-1:0] gWdata;
    logic              gAck;
    logic              gValid;
    logic [DATA_W-1:0] gData;
    logic              gStarved;
    // memory controller
    logic              memReady;
    logic              memEn;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;

    modport slave (
        input  dReq, dAddr, gReq, gWe, gAddr, gWdata, memReady, memRdata,
        output dAck, dValid, dData, gAck, gValid, gData, gStarved,
               memEn, memWe, memAddr, memWdata
    );

    modport master (
        output dReq, dAddr, gReq, gWe, gAddr, gWdata, memReady, memRdata,
        input  dAck, dValid, dData, gAck, gValid, gData, gStarved,
               memEn, memWe, memAddr, memWdata
    );
endinterface

// File: rtl/frame_mem_arbiter_read_tag_pipe.sv
// read_tag_pipe: DEPTH-deep shift register of {valid, tag} entries that
// travels alongside the memory read latency, so the entry leaving the last
// stage lines up with the memRdata word it describes.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low clear (drops every in-flight entry)
//   push - entry entering the pipe this cycle
//   pop  - entry leaving the pipe this cycle
module read_tag_pipe
    import frame_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = MEM_LAT_DEF
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t push,
    output rd_tag_t pop
);

    rd_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign pop = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares one single-port frame memory between the VGA
// scan-out fetch (display, read-only, priority) and the Game of Life engine
// (game, read/write, bounded wait). One registered command per cycle; read
// data is routed back to whichever requester issued the read.
// Ports:
//   clk - system clock
//   rst - asynchronous active-low reset
//   bus - client handshakes, return data and memory command/response
//         (frame_mem_arbiter_if, slave view)
module frame_mem_arbiter
    import frame_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MEM_LAT  = MEM_LAT_DEF,   // >= 1
    parameter int MAX_WAIT = MAX_WAIT_DEF   // >= 1
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_mem_arbiter_if.slave    bus
);

    localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    logic              d_ack, g_ack;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              g_starved_q;

    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    tag_e              mem_tag_q,   mem_tag_d;

    logic              d_valid_q, d_valid_d;
    logic              g_valid_q, g_valid_d;
    logic [DATA_W-1:0] d_data_q,  d_data_d;
    logic [DATA_W-1:0] g_data_q,  g_data_d;

    rd_tag_t           tag_push, tag_pop;

    // Arbitration. rst gates the acks so nothing is accepted while the
    // block is held in reset.
    always_comb begin
        d_ack = 1'b0;
        g_ack = 1'b0;
        if (rst && bus.memReady) begin
            if (bus.dReq && bus.gReq) begin
                if (wait_cnt_q == WAIT_MAX) g_ack = 1'b1;
                else                        d_ack = 1'b1;
            end else if (bus.dReq) begin
                d_ack = 1'b1;
            end else if (bus.gReq) begin
                g_ack = 1'b1;
            end
        end
    end

    // Bounded-wait counter: counts cycles the game loses to the display.
    // Frozen while memory is busy so a refresh does not eat into the
    // game's guarantee.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (bus.memReady) begin
            if (!bus.gReq || g_ack) begin
                wait_cnt_d = '0;
            end else if (d_ack && wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    // Command issue. Address/data/tag hold their last value when idle;
    // only memEn qualifies them.
    always_comb begin
        mem_en_d    = d_ack | g_ack;
        mem_we_d    = g_ack & bus.gWe;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_tag_d   = mem_tag_q;
        if (g_ack) begin
            mem_addr_d  = bus.gAddr;
            mem_wdata_d = bus.gWdata;
            mem_tag_d   = TAG_GAME;
        end else if (d_ack) begin
            mem_addr_d  = bus.dAddr;
            mem_tag_d   = TAG_DISP;
        end
    end

    // The pipe is fed from the registered command, so its last stage is
    // visible exactly in the cycle the memory drives the read data.
    assign tag_push = '{valid: mem_en_q & ~mem_we_q, tag: mem_tag_q};

    read_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .clk  (clk),
        .rst  (rst),
        .push (tag_push),
        .pop  (tag_pop)
    );

    // Return routing: only the addressed client's data register loads.
    always_comb begin
        d_valid_d = tag_pop.valid && (tag_pop.tag == TAG_DISP);
        g_valid_d = tag_pop.valid && (tag_pop.tag == TAG_GAME);
        d_data_d  = d_valid_d ? bus.memRdata : d_data_q;
        g_data_d  = g_valid_d ? bus.memRdata : g_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q  <= '0;
            g_starved_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_tag_q   <= TAG_DISP;
            d_valid_q   <= 1'b0;
            g_valid_q   <= 1'b0;
            d_data_q    <= '0;
            g_data_q    <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            // Registered from the next count so it tracks wait_cnt_q exactly.
            g_starved_q <= (wait_cnt_d == WAIT_MAX);
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_tag_q   <= mem_tag_d;
            d_valid_q   <= d_valid_d;
            g_valid_q   <= g_valid_d;
            d_data_q    <= d_data_d;
            g_data_q    <= g_data_d;
        end
    end

    assign bus.dAck     = d_ack;
    assign bus.gAck     = g_ack;
    assign bus.gStarved = g_starved_q;
    assign bus.memEn    = mem_en_q;
    assign bus.memWe    = mem_we_q;
    assign bus.memAddr  = mem_addr_q;
    assign bus.memWdata = mem_wdata_q;
    assign bus.dValid   = d_valid_q;
    assign bus.gValid   = g_valid_q;
    assign bus.dData    = d_data_q;
    assign bus.gData    = g_data_q;

endmodule

// File: doc/frame_mem_arbiter.md
Name: frame_mem_arbiter

Overview:
Shares one single-port frame memory between two requesters. The VGA scan-out fetch (display, read-only) has latency-critical priority. The Game of Life update engine (game, read/write) is guaranteed progress by a bounded-wait rule. The block sits between those two clients and the frame memory controller. It issues one registered command per cycle and routes returning read data back to the requester that issued the read.

Parameters:
ADDR_W, 16, memory word address width
DATA_W, 16, memory data width
MEM_LAT, 3, cycles from memEn (read) to memRdata valid; must be >= 1
MAX_WAIT, 8, max consecutive cycles game may be denied while display is granted; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
dReq  in  1  display read request; dAddr held stable until dAck
dAddr  in  ADDR_W  display read address
dAck  out  1  combinational; display request accepted this cycle
dValid  out  1  one-cycle pulse, display read data valid
dData  out  DATA_W  display read data
gReq  in  1  game request; gWe/gAddr/gWdata held stable until gAck
gWe  in  1  1 = write, 0 = read
gAddr  in  ADDR_W  game address
gWdata  in  DATA_W  game write data
gAck  out  1  combinational; game request accepted this cycle
gValid  out  1  one-cycle pulse, game read data valid
gData  out  DATA_W  game read data
gStarved  out  1  registered; high while waitCnt == MAX_WAIT
memReady  in  1  memory can accept a command this cycle (low during refresh/busy)
memEn  out  1  registered command strobe
memWe  out  1  registered write enable
memAddr  out  ADDR_W  registered address
memWdata  out  DATA_W  registered write data
memRdata  in  DATA_W  read data, valid MEM_LAT cycles after a read memEn

Behaviour:
- Reset (rst=0, async):
  - memEn, memWe, memAddr, memWdata, dValid, gValid, dData, gData, gStarved = 0.
  - waitCnt = 0; tag pipeline cleared.
  - dAck/gAck are 0 while in reset.
- Arbitration, evaluated each cycle, combinational:
  - memReady=0: no ack.
  - Only dReq: dAck=1. Only gReq: gAck=1.
  - Both requesting: gAck=1 if waitCnt == MAX_WAIT, else dAck=1.
  - At most one ack per cycle.
- Issue: at the edge ending ack cycle A, the granted request is registered onto memEn/memWe/memAddr/memWdata, visible in cycle A+1.
  - Display commands always have memWe=0.
  - memEn=0 in any cycle following a no-ack cycle.
  - Back-to-back acks to the same requester are allowed, one per cycle.
- waitCnt (0..MAX_WAIT, saturating):
  - Increments when gReq=1 and dAck=1.
  - Cleared on gAck or when gReq=0.
  - Holds when memReady=0.
  - gStarved = (waitCnt == MAX_WAIT), registered from waitCnt.
- Read return:
  - Each issued read pushes {valid=1, tag} into a MEM_LAT-deep shift pipeline aligned with memRdata; writes and idle cycles push valid=0.
  - For a read issued in cycle A+1, memRdata is sampled in cycle A+1+MEM_LAT.
  - dData or gData is registered per tag, and the matching dValid/gValid is high in cycle A+2+MEM_LAT for exactly one cycle.
  - The non-matching data output holds its previous value.
  - Returns arrive strictly in issue order.
  - memReady=0 does not stall the pipeline; in-flight reads still return.
- Reset mid-operation: in-flight reads are discarded; no valid pulses after reset release until new reads are issued.
- Request withdrawn before ack: legal, no side effect. Changing address while req=1 and unacked is illegal (assertion in bench).

Decomposition:
- Shared package: tag encoding (TAG_DISP=1'b0, TAG_GAME=1'b1) and default ADDR_W/DATA_W/MEM_LAT values shared with the VGA controller, the Game of Life engine and the memory controller.
- One sub-module: read_tag_pipe, a parameterised MEM_LAT-deep {valid, tag} shift register with async active-low clear.

Test Plan:
- Reset: hold rst=0 with dReq=gReq=1 → all registered outputs 0, dAck=gAck=0; release → dAck=1 in first cycle.
- Display read alone: dReq, dAddr=0x0010 acked in cycle A; memRdata=0xBEEF at A+4 (MEM_LAT=3) → memEn=1, memWe=0, memAddr=0x0010 at A+1; dValid=1, dData=0xBEEF at A+5; gValid stays 0.
- Game write alone: gWe=1, gAddr=0x0200, gWdata=0x1234 → gAck at A; memEn=memWe=1, memAddr=0x0200, memWdata=0x1234 at A+1; no gValid ever.
- Contention: dReq and gReq held high for 40 cycles (MAX_WAIT=8) → repeating pattern of 8 dAcks then 1 gAck; gStarved high in each gAck cycle; memEn high every cycle.
- memReady low for 4 cycles under contention → no acks, memEn=0 in the 4 following cycles, waitCnt unchanged; pattern resumes when memReady returns high.
- Interleaved reads d(0x1), g(0x2), d(0x3) back-to-back, memRdata 0xA,0xB,0xC → dValid/0xA, gValid/0xB, dValid/0xC in consecutive cycles; repeat with rst pulsed low right after the third ack → no valids observed.
